// File: rtl/ssy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ssy_pkg
// Brief    : Shared types and helpers for the ssy_multi_grant arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ssy_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } ssy_state_t;

  // Width of the hold counter; MAX_HOLD never exceeds 255 so it cannot wrap
  localparam int HOLD_W = 8;

  // Channel index width, at least one bit even for tiny arbiters
  function automatic int calc_idw(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ssy_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : ssy_rr_pick
// Brief    : Combinational winner picker. Round-robin search starting just
//            after last_id, or fixed lowest-index priority.
// Revision : 1.0 - initial release
// ============================================================================
module ssy_rr_pick
  import ssy_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = calc_idw(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] request,
  input  logic [IDW-1:0]     last_id,
  input  logic               rr_mode,
  output logic               valid,
  output logic [IDW-1:0]     pick_id,
  output logic [NUM_REQ-1:0] pick_onehot
);

  // Scan channels in search order and keep the first requester found
  always_comb begin
    int   idx;
    logic found;
    idx         = 0;
    found       = 1'b0;
    valid       = |request;
    pick_id     = '0;
    pick_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_mode) begin
        // Two conditional subtractions fold any last_id encoding back into range
        idx = int'(last_id) + 1 + i;
        if (idx >= NUM_REQ) begin
          idx = idx - NUM_REQ;
        end
        if (idx >= NUM_REQ) begin
          idx = idx - NUM_REQ;
        end
      end else begin
        idx = i;
      end
      if (!found && request[idx]) begin
        found   = 1'b1;
        pick_id = IDW'(idx);
      end
    end
    if (valid) begin
      pick_onehot[pick_id] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ssy_multi_grant.sv
`default_nettype none
// ============================================================================
// Module   : ssy_multi_grant
// Brief    : N-channel request/grant arbiter. One grant at a time, held while
//            its request stays high up to MAX_HOLD cycles, then a one-cycle
//            gap before the next arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module ssy_multi_grant
  import ssy_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 8,
  parameter  int RR_MODE  = 1,
  localparam int IDW      = calc_idw(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] request,
  output logic               idle,
  output logic [NUM_REQ-1:0] granted,
  output logic [IDW-1:0]     grant_id,
  output logic               expired
);

  localparam logic              RR_EN      = (RR_MODE != 0);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [IDW-1:0]    LAST_RST   = IDW'(NUM_REQ - 1);

  ssy_state_t          state_q,    state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [IDW-1:0]      last_id_q,  last_id_d;
  logic [NUM_REQ-1:0]  granted_q,  granted_d;
  logic [IDW-1:0]      grant_id_q, grant_id_d;
  logic                expired_q,  expired_d;

  logic                pick_valid;
  logic [IDW-1:0]      pick_id;
  logic [NUM_REQ-1:0]  pick_onehot;

  ssy_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .request     (request),
    .last_id     (last_id_q),
    .rr_mode     (RR_EN),
    .valid       (pick_valid),
    .pick_id     (pick_id),
    .pick_onehot (pick_onehot)
  );

  // Next-state logic: arbitration in IDLE, hold/limit tracking in GRANT
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_id_d  = last_id_q;
    granted_d  = granted_q;
    grant_id_d = grant_id_q;
    expired_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d    = S_GRANT;
          granted_d  = pick_onehot;
          grant_id_d = pick_id;
          hold_cnt_d = HOLD_W'(1);
          if (RR_EN) begin
            last_id_d = pick_id;
          end
        end
      end
      S_GRANT: begin
        // A dropped request wins over the limit, so expired stays low then
        if (!request[grant_id_q]) begin
          state_d   = S_GAP;
          granted_d = '0;
        end else if (hold_cnt_q == HOLD_LIMIT) begin
          state_d   = S_GAP;
          granted_d = '0;
          expired_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        granted_d = '0;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      last_id_q  <= LAST_RST;
      granted_q  <= '0;
      grant_id_q <= '0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_id_q  <= last_id_d;
      granted_q  <= granted_d;
      grant_id_q <= grant_id_d;
      expired_q  <= expired_d;
    end
  end

  assign idle     = (state_q == S_IDLE);
  assign granted  = granted_q;
  assign grant_id = grant_id_q;
  assign expired  = expired_q;

endmodule
`default_nettype wire

// File: tb/tb_ssy_multi_grant.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssy_multi_grant
// Brief    : Self-checking bench for three arbiter configurations
//            (4ch round-robin, 4ch fixed priority, 3ch round-robin).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssy_multi_grant;

  localparam int MAXH = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req_a, req_b;
  logic [2:0] req_c;

  logic       idle_a, exp_a, idle_b, exp_b, idle_c, exp_c;
  logic [3:0] gnt_a, gnt_b;
  logic [2:0] gnt_c;
  logic [1:0] gid_a, gid_b, gid_c;

  always #5 clk = ~clk;

  ssy_multi_grant #(.NUM_REQ(4), .MAX_HOLD(MAXH), .RR_MODE(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .request(req_a), .idle(idle_a),
    .granted(gnt_a), .grant_id(gid_a), .expired(exp_a));

  ssy_multi_grant #(.NUM_REQ(4), .MAX_HOLD(MAXH), .RR_MODE(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .request(req_b), .idle(idle_b),
    .granted(gnt_b), .grant_id(gid_b), .expired(exp_b));

  ssy_multi_grant #(.NUM_REQ(3), .MAX_HOLD(MAXH), .RR_MODE(1)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .request(req_c), .idle(idle_c),
    .granted(gnt_c), .grant_id(gid_c), .expired(exp_c));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic idl, input logic ex,
                                       input logic [7:0] gid, input logic [31:0] g);
    return {22'd0, idl, ex, gid, g};
  endfunction

  // Reference model, one slot per DUT (0=idle, 1=grant, 2=gap)
  int          m_n[3]  = '{4, 4, 3};
  bit          m_rr[3] = '{1'b1, 1'b0, 1'b1};
  int          m_st[3], m_hold[3], m_last[3], m_gid[3];
  logic [31:0] m_gnt[3];
  logic        m_exp[3];
  logic [63:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i]   = 0;
      m_hold[i] = 0;
      m_last[i] = m_n[i] - 1;
      m_gid[i]  = 0;
      m_gnt[i]  = '0;
      m_exp[i]  = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input logic [31:0] req);
    int k;
    int c;
    k = -1;
    m_exp[i] = 1'b0;
    case (m_st[i])
      0: begin
        if (req != 0) begin
          if (m_rr[i]) begin
            for (int off = 1; off <= m_n[i]; off++) begin
              c = (m_last[i] + off) % m_n[i];
              if (k < 0 && req[c]) k = c;
            end
          end else begin
            for (int j = 0; j < m_n[i]; j++) begin
              if (k < 0 && req[j]) k = j;
            end
          end
          m_st[i]   = 1;
          m_gnt[i]  = 32'd1 << k;
          m_gid[i]  = k;
          m_hold[i] = 1;
          m_last[i] = k;
        end
      end
      1: begin
        if (!req[m_gid[i]]) begin
          m_st[i]  = 2;
          m_gnt[i] = '0;
        end else if (m_hold[i] == MAXH) begin
          m_st[i]  = 2;
          m_gnt[i] = '0;
          m_exp[i] = 1'b1;
        end else begin
          m_hold[i]++;
        end
      end
      default: m_st[i] = 0;
    endcase
  endtask

  function automatic logic [63:0] model_out(input int i);
    return pack(m_st[i] == 0, m_exp[i], 8'(m_gid[i]), m_gnt[i]);
  endfunction

  // Observation state used by the directed checks
  logic [3:0] a_prev, b_prev;
  logic [2:0] c_prev;
  int         a_len, a_exp_cnt, b_ch1, b_ch3;
  int         a_seq[$], a_lens[$], c_seq[$];
  int         exp_rot[5] = '{0, 1, 2, 3, 0};

  task automatic clear_mon();
    a_seq.delete();
    a_lens.delete();
    c_seq.delete();
    a_len     = 0;
    a_exp_cnt = 0;
    a_prev    = '0;
    b_prev    = '0;
    c_prev    = '0;
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge
  task automatic step(input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] rc);
    req_a = ra;
    req_b = rb;
    req_c = rc;
    model_step(0, 32'(ra));
    model_step(1, 32'(rb));
    model_step(2, 32'(rc));
    for (int i = 0; i < 3; i++) exp_q.push_back(model_out(i));
    @(posedge clk);
    #1;
    check("cyc_A", pack(idle_a, exp_a, 8'(gid_a), 32'(gnt_a)), exp_q.pop_front());
    check("cyc_B", pack(idle_b, exp_b, 8'(gid_b), 32'(gnt_b)), exp_q.pop_front());
    check("cyc_C", pack(idle_c, exp_c, 8'(gid_c), 32'(gnt_c)), exp_q.pop_front());
    if (gnt_a != 0 && a_prev == 0) begin
      a_seq.push_back(int'(gid_a));
      a_len = 0;
    end
    if (gnt_a != 0) a_len++;
    if (gnt_a == 0 && a_prev != 0) a_lens.push_back(a_len);
    if (exp_a) a_exp_cnt++;
    a_prev = gnt_a;
    if (gnt_b != 0 && b_prev == 0) begin
      if (gid_b == 2'd1) b_ch1++;
      if (gid_b == 2'd3) b_ch3++;
    end
    b_prev = gnt_b;
    if (gnt_c != 0 && c_prev == 0) c_seq.push_back(int'(gid_c));
    c_prev = gnt_c;
  endtask

  // Called 1 time unit after a rising edge; asserts reset between edges
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_A", pack(idle_a, exp_a, 8'(gid_a), 32'(gnt_a)), model_out(0));
    check("rst_B", pack(idle_b, exp_b, 8'(gid_b), 32'(gnt_b)), model_out(1));
    check("rst_C", pack(idle_c, exp_c, 8'(gid_c), 32'(gnt_c)), model_out(2));
    #2;
    reset_n = 1'b1;
    clear_mon();
  endtask

  initial begin
    reset_n = 1'b0;
    req_a   = '0;
    req_b   = '0;
    req_c   = '0;
    b_ch1   = 0;
    b_ch3   = 0;
    model_reset();
    clear_mon();
    @(posedge clk);
    #1;
    do_reset();

    // Single request on A, fixed priority on B, wrap-around on C
    for (int s = 0; s < 20; s++) begin
      step((s < 3) ? 4'b0100 : 4'b0000,
           4'b1010,
           (s < 3) ? 3'b100 : ((s >= 6 && s < 10) ? 3'b101 : 3'b000));
    end
    check("single_id",   64'((a_seq.size() > 0) ? a_seq[0] : -1), 64'd2);
    check("single_len",  64'((a_lens.size() > 0) ? a_lens[0] : -1), 64'd3);
    check("single_exp",  64'(a_exp_cnt), 64'd0);
    check("single_idle", 64'(idle_a), 64'd1);
    check("wrap_first",  64'((c_seq.size() > 0) ? c_seq[0] : -1), 64'd2);
    check("wrap_second", 64'((c_seq.size() > 1) ? c_seq[1] : -1), 64'd0);

    // Reset in grant cycle 3, then 0011 must go to channel 0
    clear_mon();
    for (int s = 0; s < 3; s++) step(4'b0001, 4'b0000, 3'b000);
    do_reset();
    check("rstmid_gnt",  64'(gnt_a), 64'd0);
    check("rstmid_idle", 64'(idle_a), 64'd1);
    for (int s = 0; s < 4; s++) step(4'b0011, 4'b0000, 3'b000);
    check("rstmid_first", 64'((a_seq.size() > 0) ? a_seq[0] : -1), 64'd0);
    for (int s = 0; s < 4; s++) step(4'b0000, 4'b0000, 3'b000);

    // Round-robin rotation with every grant running to the limit
    do_reset();
    for (int s = 0; s < 52; s++) step(4'b1111, 4'b1010, 3'b111);
    for (int r = 0; r < 5; r++) begin
      check("rr_order", 64'((a_seq.size() > r) ? a_seq[r] : -1), 64'(exp_rot[r]));
    end
    for (int r = 0; r < 4; r++) begin
      check("rr_len", 64'((a_lens.size() > r) ? a_lens[r] : -1), 64'(MAXH));
    end
    check("rr_expired", 64'(a_exp_cnt), 64'd5);
    check("fp_ch3_never", 64'(b_ch3), 64'd0);
    check("fp_ch1_wins",  64'(b_ch1 > 0), 64'd1);
    for (int s = 0; s < 4; s++) step(4'b0000, 4'b0000, 3'b000);

    // Request drops in the same cycle the hold limit is reached
    clear_mon();
    for (int s = 0; s < 8; s++) step(4'b0001, 4'b0000, 3'b000);
    for (int s = 0; s < 4; s++) step(4'b0000, 4'b0000, 3'b000);
    check("drop_len", 64'((a_lens.size() > 0) ? a_lens[0] : -1), 64'(MAXH));
    check("drop_exp", 64'(a_exp_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
